serial_subtractor: RTL

- Bit-serial, LSB-first subtractor that computes diff = a - b over WIDTH cycles and reports the final borrow.
- It is the inverse-direction companion to the existing combinational half-adder arithmetic cells.
- It serves area-constrained datapaths: one full-subtractor cell plus one borrow flip-flop replaces a WIDTH-bit ripple subtractor.
- The start/done handshake lets a controller launch a subtraction and collect the result.

---
 rtl/arith_pkg.sv | 12 +
 rtl/full_sub.sv | 13 +
 rtl/serial_subtractor.sv | 113 +++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared types and limits for the serial arithmetic cells
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  localparam int MAX_SERIAL_WIDTH = 32;

endpackage

// File: rtl/full_sub.sv
// rtl/full_sub.sv - combinational one-bit full subtractor (x - y - bin)
module full_sub (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor with start/done handshake
module serial_subtractor
  import arith_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  sub_state_t       r_state;
  sub_state_t       w_next_state;

  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic [CNT_W-1:0] r_cnt;
  logic             r_br;
  logic             r_borrow_out;
  logic             r_done;

  logic             w_d;
  logic             w_bout;
  logic             w_load;
  logic             w_shift;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  full_sub u_full_sub (
    .x    (r_sa[0]),
    .y    (r_sb[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_bout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = SHIFT;
      SHIFT:   if (r_cnt == CNT_W'(WIDTH - 1)) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_load  = (r_state == IDLE) && start;
    w_shift = (r_state == SHIFT);
    w_last  = w_shift && (r_cnt == CNT_W'(WIDTH - 1));
    busy    = (r_state == SHIFT);
  end

  // New difference bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
  always_comb begin
    w_res_next            = r_res >> 1;
    w_res_next[WIDTH-1]   = w_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sa         <= '0;
      r_sb         <= '0;
      r_res        <= '0;
      r_diff       <= '0;
      r_cnt        <= '0;
      r_br         <= 1'b0;
      r_borrow_out <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_load) begin
        r_sa  <= a;
        r_sb  <= b;
        r_res <= '0;
        r_br  <= 1'b0;
        r_cnt <= '0;
      end else if (w_shift) begin
        r_sa  <= r_sa >> 1;
        r_sb  <= r_sb >> 1;
        r_res <= w_res_next;
        r_br  <= w_bout;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_last) begin
        r_diff       <= w_res_next;
        r_borrow_out <= w_bout;
      end
    end
  end

  assign done       = r_done;
  assign diff       = r_diff;
  assign borrow_out = r_borrow_out;

endmodule
